// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode: opcode-derived format, XLEN immediate, illegal flag; one-cycle latency.
// Valid/ready output with a two-entry skid; in_ready is !skid_valid (registered), flush drops everything.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } pay_t;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [7:0]      w_oh;
  logic            w_bad_opc;
  logic            w_sh_bad;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh, w_imm_z;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;
  logic            w_acc;
  logic            w_drain;
  pay_t            w_new;

  pay_t            r_out, r_skid;
  logic            r_out_vld, r_skid_vld;
  logic [CNT_W-1:0] r_cnt;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];

  // One-hot over format codes; bit k set means fmt k. All-zero means unsupported opcode.
  always_comb begin
    w_oh      = '0;
    w_bad_opc = 1'b0;
    case (w_opc)
      7'b0000011, 7'b1100111: w_oh[1] = 1'b1;
      7'b0010011: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) w_oh[6] = 1'b1;
        else                                  w_oh[1] = 1'b1;
      end
      7'b0100011:             w_oh[2] = 1'b1;
      7'b1100011:             w_oh[3] = 1'b1;
      7'b0110111, 7'b0010111: w_oh[4] = 1'b1;
      7'b1101111:             w_oh[5] = 1'b1;
      7'b0110011:             w_oh[0] = 1'b1;
      7'b1110011: begin
        if (w_f3[2]) w_oh[7] = 1'b1;
        else         w_oh[1] = 1'b1;
      end
      default:                w_bad_opc = 1'b1;
    endcase
  end

  always_comb begin
    w_imm_i        = {XLEN{in_instr[31]}};
    w_imm_i[11:0]  = in_instr[31:20];
    w_imm_s        = {XLEN{in_instr[31]}};
    w_imm_s[11:0]  = {in_instr[31:25], in_instr[11:7]};
    w_imm_b        = {XLEN{in_instr[31]}};
    w_imm_b[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    w_imm_u        = {XLEN{in_instr[31]}};
    w_imm_u[31:0]  = {in_instr[31:12], 12'b0};
    w_imm_j        = {XLEN{in_instr[31]}};
    w_imm_j[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    w_imm_sh       = '0;
    if (XLEN == 64) w_imm_sh[5:0] = in_instr[25:20];
    else            w_imm_sh[4:0] = in_instr[24:20];
    w_imm_z        = '0;
    w_imm_z[4:0]   = in_instr[19:15];
  end

  // RV32 has only 5-bit shift amounts, so instr[25] set is a reserved encoding there.
  assign w_sh_bad = (XLEN == 32) && in_instr[25];

  always_comb begin
    w_imm = '0;
    w_fmt = 3'd0;
    case (w_oh)
      8'b0000_0010: begin w_imm = w_imm_i; w_fmt = 3'd1; end
      8'b0000_0100: begin w_imm = w_imm_s; w_fmt = 3'd2; end
      8'b0000_1000: begin w_imm = w_imm_b; w_fmt = 3'd3; end
      8'b0001_0000: begin w_imm = w_imm_u; w_fmt = 3'd4; end
      8'b0010_0000: begin w_imm = w_imm_j; w_fmt = 3'd5; end
      8'b0100_0000: begin w_imm = w_sh_bad ? '0 : w_imm_sh; w_fmt = 3'd6; end
      8'b1000_0000: begin w_imm = w_imm_z; w_fmt = 3'd7; end
      default:      begin w_imm = '0;      w_fmt = 3'd0; end
    endcase
  end

  assign w_ill   = w_bad_opc || (w_oh[6] && w_sh_bad);
  assign w_new   = '{imm: w_imm, fmt: w_fmt, ill: w_ill, tag: in_tag};
  assign w_acc   = in_valid && !r_skid_vld;
  assign w_drain = !r_out_vld || out_ready;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_cnt      <= '0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      if (w_drain) begin
        // A full skid implies in_ready=0, so no new entry competes with the skid move.
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end else if (w_acc) begin
          r_out      <= w_new;
          r_out_vld  <= 1'b1;
        end else begin
          r_out_vld  <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid     <= w_new;
        r_skid_vld <= 1'b1;
      end
      if (w_acc && w_ill && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = !r_skid_vld;
  assign out_valid   = r_out_vld;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.ill;
  assign out_tag     = r_out.tag;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: RV32 (2-bit counter) and RV64 instances share one stimulus stream.
module tb_imm_decode_stage;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTn, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [1:0]  cnt32;
  logic [15:0] cnt64;

  imm_decode_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
    .CLK(CLK), .RSTn(RSTn), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32), .illegal_cnt(cnt32));

  imm_decode_stage #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut64 (
    .CLK(CLK), .RSTn(RSTn), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64), .illegal_cnt(cnt64));

  typedef struct packed {logic [63:0] imm; logic [2:0] fmt; logic ill;} dec_t;
  typedef struct {logic [31:0] instr; logic [31:0] tag;} ent_t;
  typedef struct {
    logic [31:0] instr; logic [31:0] imm32; logic [63:0] imm64;
    logic [2:0] fmt; logic ill32; logic ill64;
  } vec_t;

  ent_t q[$];
  int   m_cnt32, m_cnt64;
  int   n_cmp = 0, n_bad = 0;
  vec_t vecs[15];

  // Reference decoder: value of the immediate as a signed integer, then truncated for RV32.
  function automatic dec_t ref_dec(input logic [31:0] ins, input bit x64);
    dec_t d;
    longint v;
    logic [2:0] f3;
    f3 = ins[14:12];
    v = 0;
    d.fmt = 3'd0;
    d.ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h67: begin d.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          d.fmt = 3'd6;
          if (x64)          v = longint'(ins[25:20]);
          else if (ins[25]) begin d.ill = 1'b1; v = 0; end
          else              v = longint'(ins[24:20]);
        end else begin
          d.fmt = 3'd1; v = longint'($signed(ins[31:20]));
        end
      end
      7'h23: begin d.fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin d.fmt = 3'd3;
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h37, 7'h17: begin d.fmt = 3'd4; v = longint'($signed(ins[31:12])) * 4096; end
      7'h6F: begin d.fmt = 3'd5;
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h33: begin d.fmt = 3'd0; v = 0; end
      7'h73: begin
        if (f3[2]) begin d.fmt = 3'd7; v = longint'(ins[19:15]); end
        else       begin d.fmt = 3'd1; v = longint'($signed(ins[31:20])); end
      end
      default: begin d.ill = 1'b1; v = 0; end
    endcase
    d.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    dec_t e32, e64;
    chk("in_ready32",  64'(rdy32), 64'(q.size() < 2));
    chk("in_ready64",  64'(rdy64), 64'(q.size() < 2));
    chk("out_valid32", 64'(ov32),  64'(q.size() > 0));
    chk("out_valid64", 64'(ov64),  64'(q.size() > 0));
    chk("cnt32",       64'(cnt32), 64'(m_cnt32));
    chk("cnt64",       64'(cnt64), 64'(m_cnt64));
    if (q.size() > 0) begin
      e32 = ref_dec(q[0].instr, 1'b0);
      e64 = ref_dec(q[0].instr, 1'b1);
      chk("imm32", 64'(imm32), e32.imm);
      chk("fmt32", 64'(fmt32), 64'(e32.fmt));
      chk("ill32", 64'(ill32), 64'(e32.ill));
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("imm64", imm64,      e64.imm);
      chk("fmt64", 64'(fmt64), 64'(e64.fmt));
      chk("ill64", 64'(ill64), 64'(e64.ill));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
    end
  endtask

  // One clock edge: advance the FIFO-level model from the inputs seen at the edge, then check.
  task automatic step();
    @(posedge CLK);
    if (!RSTn) begin
      q.delete(); m_cnt32 = 0; m_cnt64 = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      bit   acc, pop;
      dec_t d32, d64;
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back('{in_instr, in_tag});
        d32 = ref_dec(in_instr, 1'b0);
        d64 = ref_dec(in_instr, 1'b1);
        if (d32.ill && m_cnt32 < 3)     m_cnt32++;
        if (d64.ill && m_cnt64 < 65535) m_cnt64++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RSTn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    RSTn = 1'b1;
  endtask

  logic [6:0] opcs [11];

  initial begin
    int seen[$];
    int nxt, saved;
    logic [31:0] r;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0, 1'b0};
    vecs[3]  = '{32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0, 1'b0};
    vecs[4]  = '{32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0};
    vecs[5]  = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd6, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1, 1'b1};
    vecs[7]  = '{32'h00B50533, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 1'b0};
    vecs[9]  = '{32'hF14AD073, 32'h00000015, 64'h0000000000000015, 3'd7, 1'b0, 1'b0};
    vecs[10] = '{32'h00100073, 32'h00000001, 64'h0000000000000001, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{32'h4035D513, 32'h00000003, 64'h0000000000000003, 3'd6, 1'b0, 1'b0};
    vecs[12] = '{32'h80002083, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0, 1'b0};
    vecs[13] = '{32'h00001097, 32'h00001000, 64'h0000000000001000, 3'd4, 1'b0, 1'b0};
    vecs[14] = '{32'h7FF080E7, 32'h000007FF, 64'h00000000000007FF, 3'd1, 1'b0, 1'b0};
    opcs = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

    RSTn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_tag = 32'h0;
    m_cnt32 = 0; m_cnt64 = 0;
    step(); step();
    chk("rst_imm32", 64'(imm32), 64'h0);
    chk("rst_imm64", imm64,      64'h0);
    chk("rst_fmt",   64'(fmt32), 64'h0);
    chk("rst_ill",   64'(ill64), 64'h0);
    chk("rst_tag",   64'(tag32), 64'h0);
    RSTn = 1'b1;

    // Directed table, one instruction per cycle with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = 32'(i + 100);
      step();
      chk("tbl_valid", 64'(ov32), 64'h1);
      chk("tbl_imm32", 64'(imm32), 64'(vecs[i].imm32));
      chk("tbl_imm64", imm64, vecs[i].imm64);
      chk("tbl_fmt32", 64'(fmt32), 64'(vecs[i].fmt));
      chk("tbl_fmt64", 64'(fmt64), 64'(vecs[i].fmt));
      chk("tbl_ill32", 64'(ill32), 64'(vecs[i].ill32));
      chk("tbl_ill64", 64'(ill64), 64'(vecs[i].ill64));
      chk("tbl_tag",   64'(tag64), 64'(i + 100));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: tags 1..4 against a stalled consumer, then release.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100013; in_tag = 32'd1;
    step();
    chk("bp_rdy_after1", 64'(rdy32), 64'h1);
    chk("bp_tag_after1", 64'(tag32), 64'd1);
    in_instr = 32'h00200013; in_tag = 32'd2;
    step();
    chk("bp_rdy_after2", 64'(rdy32), 64'h0);
    in_instr = 32'h00300013; in_tag = 32'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_stall_tag", 64'(tag32), 64'd1);
      chk("bp_stall_imm", 64'(imm32), 64'd1);
    end
    out_ready = 1'b1;
    nxt = 3;
    for (int c = 0; c < 20 && seen.size() < 4; c++) begin
      bit acc;
      acc = in_valid && rdy32;
      if (ov32 && out_ready) seen.push_back(int'(tag32));
      step();
      if (acc) begin
        if (nxt == 4) in_valid = 1'b0;
        else begin nxt = 4; in_instr = 32'h00400013; in_tag = 32'd4; end
      end
    end
    chk("bp_count", 64'(seen.size()), 64'd4);
    for (int k = 0; k < seen.size(); k++) chk("bp_order", 64'(seen[k]), 64'(k + 1));

    // Flush with both entries full and a concurrent input, then with room to accept.
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
    in_tag = 32'd10; step();
    in_tag = 32'd11; step();
    chk("fl_full", 64'(rdy32), 64'h0);
    saved = 2;
    flush = 1'b1; in_tag = 32'd12; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid",  64'(ov32),  64'h0);
    chk("fl_ready",  64'(rdy32), 64'h1);
    chk("fl_cnt32",  64'(cnt32), 64'(saved));
    chk("fl_cnt64",  64'(cnt64), 64'(saved));
    in_valid = 1'b1; flush = 1'b1; in_tag = 32'd13; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", 64'(ov64),  64'h0);
    chk("fl2_cnt64", 64'(cnt64), 64'(saved));
    step();
    chk("fl2_empty", 64'(ov64),  64'h0);

    // Counter saturation on the 2-bit instance, then reset clears it.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 32'(i); step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_cnt32", 64'(cnt32), 64'd3);
    chk("sat_cnt64", 64'(cnt64), 64'd5);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500013;
    step(); step();
    RSTn = 1'b0; step();
    RSTn = 1'b1; in_valid = 1'b0;
    chk("rst_cnt32",  64'(cnt32), 64'd0);
    chk("rst_cnt64",  64'(cnt64), 64'd0);
    chk("rst_valid",  64'(ov32),  64'h0);
    chk("rst_ready",  64'(rdy64), 64'h1);

    // Randomised traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom();
      RSTn      = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) == 0) in_instr = r;
      else in_instr = {r[31:7], opcs[$urandom_range(0, 10)]};
      in_tag = $urandom();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined immediate-decode stage for the RISC-V core. It sits between fetch and the register-read/execute stage. It derives the instruction format directly from the opcode instead of taking an external type code, and produces an XLEN-wide immediate plus a format code and an illegal flag. Output is registered behind a valid/ready handshake with a two-entry skid buffer, so the stage sustains one instruction per cycle under backpressure. It also keeps a saturating count of illegal encodings.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically the PC) carried alongside each instruction.
- CNT_W, 16, width of the illegal-instruction counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  instruction/tag present.
- in_ready  out  1  stage can accept; equals !skid_valid (a registered signal).
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ZIMM.
- out_illegal  out  1  unsupported opcode, or illegal shift encoding.
- out_tag  out  TAG_W  tag of the presented result.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

## Operation

**Format decode (by opcode, instr[6:0]):**
- 0000011, 1100111 → I.
- 0010011 → I, except when funct3 is 001 or 101 → SHAMT.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.
- 0110011 → R, with imm = 0.
- 1110011 → ZIMM when funct3[2]=1; otherwise I.
- Any other opcode → fmt 0, imm 0, illegal = 1.

**Immediate assembly:** all sign extension is from instr[31] up to XLEN.
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SHAMT: zero-extended; instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - XLEN=32 with instr[25]=1 → illegal = 1, imm = 0.
- ZIMM: instr[19:15], zero-extended.
- Selection uses a one-hot format decode with a mux. Arithmetic merging of the candidates is not allowed.

**Buffering:**
- State: output register (out_valid plus payload) and skid register (skid_valid plus payload).
- Accept condition: in_valid && in_ready.
- Accept while the output register is empty, or is being drained (out_ready=1): write the output register.
- Accept while out_valid=1 and out_ready=0: write the skid register.
- On out_ready=1 with skid_valid=1: the skid entry moves to the output register and skid_valid clears.
- Order is strictly FIFO. The payload is held stable while out_valid=1 and out_ready=0.

**Counter:**
- illegal_cnt increments when an accepted instruction decodes illegal.
- It saturates at 2^CNT_W−1.
- It is not cleared by flush.

**Flush:**
- Clears out_valid and skid_valid next cycle.
- Overrides any same-cycle accept: the input is dropped, and it is still not counted.

**Reset (RSTn=0 at an edge):**
- out_valid=0, skid_valid=0, illegal_cnt=0.
- out_imm, out_fmt, out_illegal, out_tag = 0.
- Handshakes are ignored while RSTn=0.
- Reset mid-stream discards all entries.

## Timing
- Latency: one cycle. An instruction accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 per cycle when out_ready=1 continuously.
- in_ready falls in the cycle after the skid entry fills, and rises in the cycle after the skid entry drains. There is no combinational path from out_ready to in_ready.
- Simultaneous accept and drain with skid empty: the new entry replaces the output register with no bubble.
- Simultaneous accept and drain with skid full cannot occur, because in_ready=0 while skid_valid=1.
- The counter updates on the same edge as the accept.

## Test plan
- XLEN=32, out_ready=1:
  - in_instr 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - in_instr 0xFE112E23 → imm 0xFFFFFFFC, fmt 2.
  - in_instr 0xFF9FF06F → imm 0xFFFFFFF8, fmt 5.
  - All results appear one cycle after acceptance.
- U format: in_instr 0x123452B7 → imm 0x12345000.
  - XLEN=64, in_instr 0x800002B7 → imm 0xFFFFFFFF80000000.
- Shift encoding 0x02009093:
  - XLEN=32 → illegal=1, imm 0, illegal_cnt=1.
  - XLEN=64 → fmt 6, imm 32, illegal=0.
- Backpressure: stream tags 1..4 back-to-back while out_ready=0.
  - Tags 1 and 2 are accepted; in_ready drops after tag 2.
  - Release out_ready → outputs appear in order 1, 2, 3, 4, and payloads stay stable while stalled.
- Flush with both entries full plus a concurrent in_valid → out_valid=0 next cycle, the input is dropped, and illegal_cnt is unchanged.
- Counter saturation (CNT_W=2): five illegal opcodes (e.g. 0x0000007F) → illegal_cnt sticks at 3.
  - Then assert RSTn=0 for one edge → illegal_cnt=0, out_valid=0.
